// File: rtl/rvfi_retire_unit_pkg.sv
// Shared types, constants and helpers for the RVFI retire unit.
package rvfi_retire_unit_pkg;

    localparam int RVFI_XLEN  = 32;
    localparam int RVFI_ILEN  = 32;
    localparam int RVFI_MASKW = RVFI_XLEN / 8;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam logic [1:0]  RVFI_MODE_M = 2'd3;
    localparam logic [1:0]  RVFI_IXL_32 = 2'd1;

    // Complete single-retire RVFI packet.
    typedef struct packed {
        logic                  valid;
        logic [63:0]           order;
        logic [RVFI_ILEN-1:0]  insn;
        logic                  trap;
        logic                  halt;
        logic                  intr;
        logic [1:0]            mode;
        logic [1:0]            ixl;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [RVFI_XLEN-1:0]  rs1_rdata;
        logic [RVFI_XLEN-1:0]  rs2_rdata;
        logic [4:0]            rd_addr;
        logic [RVFI_XLEN-1:0]  rd_wdata;
        logic [RVFI_XLEN-1:0]  pc_rdata;
        logic [RVFI_XLEN-1:0]  pc_wdata;
        logic [RVFI_XLEN-1:0]  mem_addr;
        logic [RVFI_MASKW-1:0] mem_rmask;
        logic [RVFI_MASKW-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]  mem_rdata;
        logic [RVFI_XLEN-1:0]  mem_wdata;
    } rvfi_pkt_t;

    // Zero every data byte whose mask bit is clear.
    function automatic logic [RVFI_XLEN-1:0] mask_bytes(
        input logic [RVFI_XLEN-1:0]  data,
        input logic [RVFI_MASKW-1:0] mask
    );
        logic [RVFI_XLEN-1:0] res;
        res = '0;
        for (int i = 0; i < RVFI_MASKW; i++) begin
            res[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/rvfi_retire_unit_normalize.sv
// Combinational cleanup of a WB retire event into an RVFI packet:
// x0 reads/writes read as zero, traps suppress side effects, and
// memory data/address are zeroed outside the active byte masks.
module rvfi_normalize
    import rvfi_retire_unit_pkg::*;
(
    input  logic [63:0]           order,
    input  logic                  intr,
    input  logic                  halt,
    input  logic [RVFI_ILEN-1:0]  insn,
    input  logic                  trap,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    input  logic [RVFI_XLEN-1:0]  rs1_rdata,
    input  logic [RVFI_XLEN-1:0]  rs2_rdata,
    input  logic [4:0]            rd_addr,
    input  logic [RVFI_XLEN-1:0]  rd_wdata,
    input  logic [RVFI_XLEN-1:0]  pc,
    input  logic [RVFI_XLEN-1:0]  next_pc,
    input  logic [RVFI_XLEN-1:0]  mem_addr,
    input  logic [RVFI_MASKW-1:0] mem_rmask,
    input  logic [RVFI_MASKW-1:0] mem_wmask,
    input  logic [RVFI_XLEN-1:0]  mem_rdata,
    input  logic [RVFI_XLEN-1:0]  mem_wdata,
    output rvfi_pkt_t             pkt
);

    logic [4:0]            rd_addr_s;
    logic [RVFI_MASKW-1:0] rmask_s;
    logic [RVFI_MASKW-1:0] wmask_s;

    // Build the cleaned packet; a trap kills the register write and any memory access.
    always_comb begin
        pkt       = '0;
        rd_addr_s = trap ? 5'd0 : rd_addr;
        rmask_s   = trap ? {RVFI_MASKW{1'b0}} : mem_rmask;
        wmask_s   = trap ? {RVFI_MASKW{1'b0}} : mem_wmask;

        pkt.valid     = 1'b1;
        pkt.order     = order;
        pkt.insn      = insn;
        pkt.trap      = trap;
        pkt.halt      = halt;
        pkt.intr      = intr;
        pkt.mode      = RVFI_MODE_M;
        pkt.ixl       = RVFI_IXL_32;
        pkt.rs1_addr  = rs1_addr;
        pkt.rs2_addr  = rs2_addr;
        pkt.rs1_rdata = (rs1_addr == 5'd0) ? {RVFI_XLEN{1'b0}} : rs1_rdata;
        pkt.rs2_rdata = (rs2_addr == 5'd0) ? {RVFI_XLEN{1'b0}} : rs2_rdata;
        pkt.rd_addr   = rd_addr_s;
        pkt.rd_wdata  = (rd_addr_s == 5'd0) ? {RVFI_XLEN{1'b0}} : rd_wdata;
        pkt.pc_rdata  = pc;
        pkt.pc_wdata  = next_pc;
        pkt.mem_rmask = rmask_s;
        pkt.mem_wmask = wmask_s;
        pkt.mem_rdata = mask_bytes(mem_rdata, rmask_s);
        pkt.mem_wdata = mask_bytes(mem_wdata, wmask_s);
        if ((rmask_s == {RVFI_MASKW{1'b0}}) && (wmask_s == {RVFI_MASKW{1'b0}})) begin
            pkt.mem_addr = {RVFI_XLEN{1'b0}};
        end else begin
            pkt.mem_addr = mem_addr;
        end
    end

endmodule

// File: rtl/rvfi_retire_unit.sv
// Registers WB retire events into the NRET=1 RVFI packet and keeps the
// order counter, halt/interrupt bookkeeping and PC-chain check.
module rvfi_retire_unit #(
    parameter int          XLEN        = 32,
    parameter int          ILEN        = 32,
    parameter logic [31:0] EBREAK_INSN = 32'h0010_0073
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wb_valid,
    input  logic [ILEN-1:0]   wb_insn,
    input  logic              wb_trap,
    input  logic [4:0]        wb_rs1_addr,
    input  logic [4:0]        wb_rs2_addr,
    input  logic [XLEN-1:0]   wb_rs1_rdata,
    input  logic [XLEN-1:0]   wb_rs2_rdata,
    input  logic [4:0]        wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_wdata,
    input  logic [XLEN-1:0]   wb_pc,
    input  logic [XLEN-1:0]   wb_next_pc,
    input  logic [XLEN-1:0]   wb_mem_addr,
    input  logic [XLEN/8-1:0] wb_mem_rmask,
    input  logic [XLEN/8-1:0] wb_mem_wmask,
    input  logic [XLEN-1:0]   wb_mem_rdata,
    input  logic [XLEN-1:0]   wb_mem_wdata,
    output logic              rvfi_valid,
    output logic [63:0]       rvfi_order,
    output logic [ILEN-1:0]   rvfi_insn,
    output logic              rvfi_trap,
    output logic              rvfi_halt,
    output logic              rvfi_intr,
    output logic [1:0]        rvfi_mode,
    output logic [1:0]        rvfi_ixl,
    output logic [4:0]        rvfi_rs1_addr,
    output logic [4:0]        rvfi_rs2_addr,
    output logic [XLEN-1:0]   rvfi_rs1_rdata,
    output logic [XLEN-1:0]   rvfi_rs2_rdata,
    output logic [4:0]        rvfi_rd_addr,
    output logic [XLEN-1:0]   rvfi_rd_wdata,
    output logic [XLEN-1:0]   rvfi_pc_rdata,
    output logic [XLEN-1:0]   rvfi_pc_wdata,
    output logic [XLEN-1:0]   rvfi_mem_addr,
    output logic [XLEN/8-1:0] rvfi_mem_rmask,
    output logic [XLEN/8-1:0] rvfi_mem_wmask,
    output logic [XLEN-1:0]   rvfi_mem_rdata,
    output logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic              halted,
    output logic              pc_chain_err
);
    import rvfi_retire_unit_pkg::*;

    rvfi_pkt_t         norm_pkt_s;
    rvfi_pkt_t         pkt_r;
    logic [63:0]       order_cnt_r;
    logic              intr_pending_r;
    logic              have_prev_r;
    logic              prev_trap_r;
    logic [XLEN-1:0]   prev_pc_r;
    logic              halted_r;
    logic              chain_err_r;
    logic              accept_s;
    logic              is_ebreak_s;
    logic              chain_bad_s;

    assign accept_s    = wb_valid & init_done & ~halted_r;
    assign is_ebreak_s = (wb_insn == EBREAK_INSN);
    assign chain_bad_s = have_prev_r & ~prev_trap_r & (wb_pc != prev_pc_r);

    rvfi_normalize u_normalize (
        .order     (order_cnt_r),
        .intr      (intr_pending_r),
        .halt      (is_ebreak_s),
        .insn      (wb_insn),
        .trap      (wb_trap),
        .rs1_addr  (wb_rs1_addr),
        .rs2_addr  (wb_rs2_addr),
        .rs1_rdata (wb_rs1_rdata),
        .rs2_rdata (wb_rs2_rdata),
        .rd_addr   (wb_rd_addr),
        .rd_wdata  (wb_rd_wdata),
        .pc        (wb_pc),
        .next_pc   (wb_next_pc),
        .mem_addr  (wb_mem_addr),
        .mem_rmask (wb_mem_rmask),
        .mem_wmask (wb_mem_wmask),
        .mem_rdata (wb_mem_rdata),
        .mem_wdata (wb_mem_wdata),
        .pkt       (norm_pkt_s)
    );

    // Output packet: capture on accept, otherwise drop valid and hold the fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_r      <= '0;
            pkt_r.mode <= RVFI_MODE_M;
            pkt_r.ixl  <= RVFI_IXL_32;
        end else if (accept_s) begin
            pkt_r <= norm_pkt_s;
        end else begin
            pkt_r.valid <= 1'b0;
        end
    end

    // Retire order counter; the explicit hold keeps the register written every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_cnt_r <= 64'd0;
        end else if (accept_s) begin
            order_cnt_r <= order_cnt_r + 64'd1;
        end else begin
            order_cnt_r <= order_cnt_r;
        end
    end

    // Halt, interrupt-pending and PC-chain bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r       <= 1'b0;
            intr_pending_r <= 1'b0;
            have_prev_r    <= 1'b0;
            prev_trap_r    <= 1'b0;
            prev_pc_r      <= '0;
            chain_err_r    <= 1'b0;
        end else if (accept_s) begin
            halted_r       <= is_ebreak_s;
            intr_pending_r <= wb_trap;
            have_prev_r    <= 1'b1;
            prev_trap_r    <= wb_trap;
            prev_pc_r      <= wb_next_pc;
            chain_err_r    <= chain_bad_s;
        end else begin
            chain_err_r    <= 1'b0;
        end
    end

    assign rvfi_valid     = pkt_r.valid;
    assign rvfi_order     = pkt_r.order;
    assign rvfi_insn      = pkt_r.insn;
    assign rvfi_trap      = pkt_r.trap;
    assign rvfi_halt      = pkt_r.halt;
    assign rvfi_intr      = pkt_r.intr;
    assign rvfi_mode      = pkt_r.mode;
    assign rvfi_ixl       = pkt_r.ixl;
    assign rvfi_rs1_addr  = pkt_r.rs1_addr;
    assign rvfi_rs2_addr  = pkt_r.rs2_addr;
    assign rvfi_rs1_rdata = pkt_r.rs1_rdata;
    assign rvfi_rs2_rdata = pkt_r.rs2_rdata;
    assign rvfi_rd_addr   = pkt_r.rd_addr;
    assign rvfi_rd_wdata  = pkt_r.rd_wdata;
    assign rvfi_pc_rdata  = pkt_r.pc_rdata;
    assign rvfi_pc_wdata  = pkt_r.pc_wdata;
    assign rvfi_mem_addr  = pkt_r.mem_addr;
    assign rvfi_mem_rmask = pkt_r.mem_rmask;
    assign rvfi_mem_wmask = pkt_r.mem_wmask;
    assign rvfi_mem_rdata = pkt_r.mem_rdata;
    assign rvfi_mem_wdata = pkt_r.mem_wdata;
    assign halted         = halted_r;
    assign pc_chain_err   = chain_err_r;

endmodule

// File: tb/tb_rvfi_retire_unit.sv
// Directed bench for rvfi_retire_unit with hand-computed expectations.
module tb_rvfi_retire_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        wb_valid;
    logic [31:0] wb_insn;
    logic        wb_trap;
    logic [4:0]  wb_rs1_addr, wb_rs2_addr, wb_rd_addr;
    logic [31:0] wb_rs1_rdata, wb_rs2_rdata, wb_rd_wdata;
    logic [31:0] wb_pc, wb_next_pc, wb_mem_addr, wb_mem_rdata, wb_mem_wdata;
    logic [3:0]  wb_mem_rmask, wb_mem_wmask;

    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        halted, pc_chain_err;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    rvfi_retire_unit dut (
        .clk(clk), .rst(rst), .init_done(init_done), .wb_valid(wb_valid),
        .wb_insn(wb_insn), .wb_trap(wb_trap),
        .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr),
        .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
        .wb_pc(wb_pc), .wb_next_pc(wb_next_pc), .wb_mem_addr(wb_mem_addr),
        .wb_mem_rmask(wb_mem_rmask), .wb_mem_wmask(wb_mem_wmask),
        .wb_mem_rdata(wb_mem_rdata), .wb_mem_wdata(wb_mem_wdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .halted(halted), .pc_chain_err(pc_chain_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0; wb_insn = 32'h0; wb_trap = 1'b0;
        wb_rs1_addr = 5'd0; wb_rs2_addr = 5'd0; wb_rd_addr = 5'd0;
        wb_rs1_rdata = 32'h0; wb_rs2_rdata = 32'h0; wb_rd_wdata = 32'h0;
        wb_pc = 32'h0; wb_next_pc = 32'h0; wb_mem_addr = 32'h0;
        wb_mem_rmask = 4'h0; wb_mem_wmask = 4'h0;
        wb_mem_rdata = 32'h0; wb_mem_wdata = 32'h0;
    endtask

    task automatic set_basic(input logic [31:0] pc, input logic [31:0] insn);
        clear_wb();
        wb_valid = 1'b1; wb_pc = pc; wb_next_pc = pc + 32'd4; wb_insn = insn;
        wb_rd_addr = 5'd1; wb_rd_wdata = 32'd1;
    endtask

    task automatic do_reset();
        clear_wb();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_wb();
        init_done = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_valid", rvfi_valid, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_chain", pc_chain_err, 1'b0);
        check_eq("rst_order", rvfi_order, 64'd0);
        check_eq("rst_mode", rvfi_mode, 2'd3);
        check_eq("rst_ixl", rvfi_ixl, 2'd1);

        // Three back-to-back ADDIs.
        init_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_basic(32'(4 * i), ADDI);
            step();
            check_eq("b2b_valid", rvfi_valid, 1'b1);
            check_eq("b2b_order", rvfi_order, 64'(i));
            check_eq("b2b_pc", rvfi_pc_rdata, 64'(4 * i));
            check_eq("b2b_npc", rvfi_pc_wdata, 64'(4 * i + 4));
            check_eq("b2b_rd", rvfi_rd_wdata, 64'd1);
            check_eq("b2b_chain", pc_chain_err, 1'b0);
        end
        clear_wb();
        step();
        check_eq("idle_valid", rvfi_valid, 1'b0);
        check_eq("idle_hold_order", rvfi_order, 64'd2);

        // Retire attempts before init_done are dropped.
        init_done = 1'b0;
        do_reset();
        set_basic(32'h0, ADDI);
        step();
        check_eq("noinit_valid0", rvfi_valid, 1'b0);
        step();
        check_eq("noinit_valid1", rvfi_valid, 1'b0);
        init_done = 1'b1;
        step();
        check_eq("init_valid", rvfi_valid, 1'b1);
        check_eq("init_order", rvfi_order, 64'd0);
        clear_wb();
        step();
        check_eq("init_single", rvfi_valid, 1'b0);

        // EBREAK terminates the trace.
        set_basic(32'h4, EBREAK);
        step();
        check_eq("halt_valid", rvfi_valid, 1'b1);
        check_eq("halt_flag", rvfi_halt, 1'b1);
        check_eq("halt_order", rvfi_order, 64'd1);
        check_eq("halted_set", halted, 1'b1);
        set_basic(32'h8, ADDI);
        step();
        check_eq("halt_ignore0", rvfi_valid, 1'b0);
        set_basic(32'hC, ADDI);
        step();
        check_eq("halt_ignore1", rvfi_valid, 1'b0);
        check_eq("halted_sticky", halted, 1'b1);
        do_reset();
        #1;
        check_eq("halt_rst", halted, 1'b0);
        set_basic(32'h0, ADDI);
        step();
        check_eq("post_halt_order", rvfi_order, 64'd0);
        check_eq("post_halt_flag", rvfi_halt, 1'b0);

        // Trap suppresses side effects and raises intr on the next retire.
        set_basic(32'h4, ADDI);
        wb_trap = 1'b1; wb_rd_addr = 5'd5; wb_rd_wdata = 32'hDEAD;
        wb_mem_wmask = 4'hF; wb_mem_addr = 32'h100; wb_mem_wdata = 32'h1122_3344;
        step();
        check_eq("trap_flag", rvfi_trap, 1'b1);
        check_eq("trap_rd_addr", rvfi_rd_addr, 5'd0);
        check_eq("trap_rd_wdata", rvfi_rd_wdata, 32'h0);
        check_eq("trap_wmask", rvfi_mem_wmask, 4'h0);
        check_eq("trap_mem_addr", rvfi_mem_addr, 32'h0);
        check_eq("trap_intr", rvfi_intr, 1'b0);
        set_basic(32'h8, ADDI);
        wb_rd_addr = 5'd5; wb_rd_wdata = 32'h7;
        step();
        check_eq("intr_set", rvfi_intr, 1'b1);
        check_eq("intr_trap0", rvfi_trap, 1'b0);
        check_eq("intr_rd_addr", rvfi_rd_addr, 5'd5);
        check_eq("intr_rd_wdata", rvfi_rd_wdata, 32'h7);
        set_basic(32'hC, ADDI);
        step();
        check_eq("intr_clear", rvfi_intr, 1'b0);

        // x0 normalisation and load byte masking.
        set_basic(32'h10, ADDI);
        wb_rd_addr = 5'd0; wb_rd_wdata = 32'h1234;
        wb_rs1_addr = 5'd0; wb_rs1_rdata = 32'h55;
        wb_rs2_addr = 5'd3; wb_rs2_rdata = 32'h77;
        wb_mem_addr = 32'h200; wb_mem_rmask = 4'b0011; wb_mem_rdata = 32'hAABB_CCDD;
        step();
        check_eq("x0_rd_wdata", rvfi_rd_wdata, 32'h0);
        check_eq("x0_rs1_rdata", rvfi_rs1_rdata, 32'h0);
        check_eq("rs2_rdata", rvfi_rs2_rdata, 32'h77);
        check_eq("load_rdata", rvfi_mem_rdata, 32'h0000_CCDD);
        check_eq("load_addr", rvfi_mem_addr, 32'h200);
        check_eq("load_chain", pc_chain_err, 1'b0);

        // PC-chain break.
        do_reset();
        set_basic(32'h10, ADDI);
        step();
        check_eq("chain_first", pc_chain_err, 1'b0);
        set_basic(32'h20, ADDI);
        step();
        check_eq("chain_break", pc_chain_err, 1'b1);
        clear_wb();
        step();
        check_eq("chain_pulse_end", pc_chain_err, 1'b0);
        set_basic(32'h24, ADDI);
        wb_trap = 1'b1;
        step();
        check_eq("chain_trap_ok", pc_chain_err, 1'b0);
        set_basic(32'h40, ADDI);
        step();
        check_eq("chain_after_trap", pc_chain_err, 1'b0);

        // Order counter wraps at 64 bits.
        clear_wb();
        force dut.order_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        release dut.order_cnt_r;
        set_basic(32'h44, ADDI);
        step();
        check_eq("wrap_max", rvfi_order, 64'hFFFF_FFFF_FFFF_FFFF);
        set_basic(32'h48, ADDI);
        step();
        check_eq("wrap_zero", rvfi_order, 64'd0);
        clear_wb();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
